// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word fetches, pairs in-order responses with
// their PCs, buffers them for decode and drops responses made stale by a redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // Stale responses can pile up across several redirects, so give discard headroom.
  localparam int DW = CW + 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   tag_pc     [DEPTH];
  logic [AW-1:0] tag_wr, tag_rd;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] discard;

  logic          grant, resp_live, resp_stale, fifo_wr, pop;
  logic [CW:0]   used;

  assign used       = {1'b0, outstanding} + {1'b0, count};
  assign imem_req   = rst_n && !redirect_valid && (used < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign grant      = imem_req && imem_gnt;
  assign resp_stale = imem_rvalid && (discard != '0);
  assign resp_live  = imem_rvalid && (discard == '0) && (outstanding != '0);
  assign fifo_wr    = resp_live && !redirect_valid;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_instr  = out_valid ? fifo_instr[rd_ptr] : NOP;
  assign out_pc     = out_valid ? fifo_pc[rd_ptr]    : RESET_PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything in flight becomes stale; a response consumed this cycle is already accounted.
      fetch_pc    <= redirect_pc & ~32'h3;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      discard     <= discard + DW'(outstanding) - DW'(resp_live || resp_stale);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      wr_ptr      <= wr_ptr + AW'(fifo_wr);
      rd_ptr      <= rd_ptr + AW'(pop);
      count       <= count + CW'(fifo_wr) - CW'(pop);
      tag_wr      <= tag_wr + AW'(grant);
      tag_rd      <= tag_rd + AW'(resp_live);
      outstanding <= outstanding + CW'(grant) - CW'(resp_live);
      discard     <= discard - DW'(resp_stale);
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_pc[tag_wr] <= fetch_pc;
    if (fifo_wr) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: an in-order memory model plus a queue-based
// reference of the fetch buffer, with a separate monitor checking the decode side.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } out_t;

  flight_t     mem_q[$];
  out_t        exp_q[$];
  logic [31:0] m_pc;
  int          cyc;
  int          lat_max;
  int          n_chk;
  int          n_fail;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Request is allowed when live in-flight fetches plus buffered words leave room.
  function automatic bit model_req();
    int live;
    live = 0;
    foreach (mem_q[i]) if (!mem_q[i].stale) live++;
    return rst_n && !redirect_valid && (live + exp_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(3))
      0:       t = 32'h0000_0103;
      1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      default: t = $urandom;
    endcase
    return t;
  endfunction

  task automatic do_cycle(input int p_gnt, input int p_ready, input int p_redir);
    bit          exp_req;
    flight_t     e;
    out_t        o;
    int          lat;
    @(negedge clk);
    cyc++;
    imem_gnt       = ($urandom_range(99) < p_gnt);
    out_ready      = ($urandom_range(99) < p_ready);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = pick_target();
    imem_rdata     = $urandom;
    imem_rvalid    = 1'b0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc && $urandom_range(99) < 80) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_q[0].data;
      end
    end else if ($urandom_range(99) < 10) begin
      imem_rvalid = 1'b1;
    end
    #1;
    exp_req = model_req();
    check32("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check32("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    if (imem_rvalid && mem_q.size() > 0) begin
      e = mem_q.pop_front();
      if (!e.stale && !redirect_valid) begin
        o.instr = e.data;
        o.pc    = e.pc;
        exp_q.push_back(o);
      end
    end
    if (exp_req && imem_gnt) begin
      lat     = $urandom_range(1, lat_max);
      e.pc    = m_pc;
      e.data  = $urandom;
      e.due   = cyc + lat;
      e.stale = 1'b0;
      mem_q.push_back(e);
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic check_reset_outputs();
    check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check32("rst_out_instr", out_instr, NOP);
    check32("rst_out_pc", out_pc, RESET_PC);
    check32("rst_imem_addr", imem_addr, RESET_PC);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    mem_q.delete();
    exp_q.delete();
    m_pc = RESET_PC;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    // A leftover response from before reset must be ignored.
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check32("first_req_after_reset", {31'b0, imem_req}, 32'd1);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        check32("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        if (out_valid && exp_q.size() > 0) begin
          check32("out_instr", out_instr, exp_q[0].instr);
          check32("out_pc", out_pc, exp_q[0].pc);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stimulus
    n_chk          = 0;
    n_fail         = 0;
    cyc            = 0;
    lat_max        = 1;
    m_pc           = RESET_PC;
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check32("first_req", {31'b0, imem_req}, 32'd1);
    @(posedge clk);

    // Streaming with single-cycle memory and an always-ready consumer.
    repeat (40) do_cycle(100, 100, 0);
    // Stalled consumer: buffer fills, requests stop, head holds.
    repeat (8) do_cycle(100, 0, 0);
    repeat (20) do_cycle(100, 100, 0);
    // Grant withheld: address must hold.
    repeat (4) do_cycle(0, 100, 0);
    // Mixed traffic with variable latency and redirects.
    lat_max = 3;
    repeat (1500) do_cycle(70, 70, 8);
    repeat (200) do_cycle(90, 90, 30);
    do_reset();
    repeat (500) do_cycle(70, 70, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
